// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a loadable pattern, overlap select and
// a saturating match counter; the match flag is a zero-latency Mealy output.
module seq_detector_param #(
    parameter int                 PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] PAT_RESET = PAT_LEN'(4'b1010),
    parameter int                 CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din_valid,
    input  logic               din,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               cnt_clr,
    output logic               dout,
    output logic [CNT_W-1:0]   match_count
);

    localparam int FW = $clog2(PAT_LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PAT_LEN-1:0] win;
    logic               accept;
    logic               match;

    assign win    = {hist_q, din};
    assign accept = din_valid & ~pat_load;
    assign match  = accept & (fill_q == FILL_MAX) & (win == pat_q);

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        if (pat_load) begin
            pat_d  = pat_in;
            fill_d = '0;
        end else if (din_valid) begin
            hist_d = win[PAT_LEN-2:0];
            // Non-overlapping mode forces a full fresh window after a hit
            if (match && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= PAT_RESET;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout        = match;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default and 2-bit counter
// instances share one stimulus stream.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid;
    logic       din;
    logic       overlap;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       cnt_clr;
    logic       dout;
    logic       dout_s;
    logic [7:0] cnt;
    logic [1:0] cnt_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_LEN(4), .PAT_RESET(4'b1010), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .dout(dout), .match_count(cnt)
    );

    seq_detector_param #(.PAT_LEN(4), .PAT_RESET(4'b1010), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .dout(dout_s), .match_count(cnt_s)
    );

    typedef struct {
        bit rst;
        bit ov;
        bit din;
        bit exp_dout;
        int exp_cnt;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_cnt(input string nm, input int exp);
        chk({nm, " cnt"}, 32'(cnt), exp);
        chk({nm, " cnt_s"}, 32'(cnt_s), (exp > 3) ? 3 : exp);
    endtask

    task automatic step(input logic v, input logic d, input logic ov,
                        input logic ld, input logic [3:0] p,
                        input logic clr, input logic exp_d,
                        input string nm);
        @(negedge clk);
        din_valid = v;
        din       = d;
        overlap   = ov;
        pat_load  = ld;
        pat_in    = p;
        cnt_clr   = clr;
        #1;
        chk({nm, " dout"}, 32'(dout), 32'(exp_d));
        chk({nm, " dout_s"}, 32'(dout_s), 32'(exp_d));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        din_valid = 1'b0;
        pat_load  = 1'b0;
        cnt_clr   = 1'b0;
        rst       = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [11:0] seq12;
        logic [6:0]  seq7;
        logic [3:0]  seq4;
        rst = 1'b1; din_valid = 1'b0; din = 1'b0; overlap = 1'b0;
        pat_load = 1'b0; pat_in = 4'd0; cnt_clr = 1'b0;
        #1;
        chk("reset dout", 32'(dout), 0);
        chk_cnt("reset", 0);
        #10;
        rst = 1'b0;

        // overlap=1: 1,0,1,0,1,0 then overlap=0: 1,0,1,0,1,0,1,0
        tbl[0]  = '{1, 1, 1, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 0};
        tbl[3]  = '{0, 1, 0, 1, 1};
        tbl[4]  = '{0, 1, 1, 0, 1};
        tbl[5]  = '{0, 1, 0, 1, 2};
        tbl[6]  = '{1, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 1, 0, 0};
        tbl[9]  = '{0, 0, 0, 1, 1};
        tbl[10] = '{0, 0, 1, 0, 1};
        tbl[11] = '{0, 0, 0, 0, 1};
        tbl[12] = '{0, 0, 1, 0, 1};
        tbl[13] = '{0, 0, 0, 1, 2};
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rst) do_reset();
            step(1'b1, tbl[i].din, tbl[i].ov, 1'b0, 4'd0, 1'b0,
                 tbl[i].exp_dout, $sformatf("tbl%0d", i));
            chk_cnt($sformatf("tbl%0d", i), tbl[i].exp_cnt);
        end

        // Valid gaps with random din while invalid
        do_reset();
        seq4 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq4[3-i], 1'b1, 1'b0, 4'd0, 1'b0, (i == 3),
                 $sformatf("gap bit%0d", i));
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 4'd0,
                         1'b0, 1'b0, $sformatf("gap idle%0d_%0d", i, g));
                end
            end
        end
        chk_cnt("gap", 1);

        // Pattern load with a coincident bit that must be dropped
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, "load");
        seq7 = 7'b0110110;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, seq7[6-i], 1'b1, 1'b0, 4'd0, 1'b0, (i == 3 || i == 6),
                 $sformatf("pat bit%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq4[3-i], 1'b1, 1'b0, 4'd0, 1'b0, 1'b0,
                 $sformatf("pat old%0d", i));
        end
        chk_cnt("pat", 2);

        // Saturation of the 2-bit counter, then clear colliding with a match
        do_reset();
        seq12 = 12'b101010101010;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, seq12[11-i], 1'b1, 1'b0, 4'd0, 1'b0,
                 (i >= 3 && i[0]), $sformatf("sat bit%0d", i));
        end
        chk("sat cnt", 32'(cnt), 5);
        chk("sat cnt_s", 32'(cnt_s), 3);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "clr pre");
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, "clr hit");
        chk("clr cnt", 32'(cnt), 0);
        chk("clr cnt_s", 32'(cnt_s), 0);

        // Async reset between edges while a match is being presented
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, seq12[11-i], 1'b1, 1'b0, 4'd0, 1'b0,
                 (i == 3 || i == 5), $sformatf("ar bit%0d", i));
        end
        chk_cnt("ar pre", 2);
        @(negedge clk);
        din_valid = 1'b1; din = 1'b0; overlap = 1'b1;
        pat_load = 1'b0; cnt_clr = 1'b0;
        #1;
        chk("ar before rst dout", 32'(dout), 1);
        rst = 1'b1;
        #1;
        chk("ar in rst dout", 32'(dout), 0);
        chk_cnt("ar in rst", 0);
        rst = 1'b0;
        #1;
        chk("ar after rst dout", 32'(dout), 0);
        @(posedge clk);
        #1;
        chk_cnt("ar post bit", 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq4[3-i], 1'b1, 1'b0, 4'd0, 1'b0, (i == 3),
                 $sformatf("ar fresh%0d", i));
        end
        chk_cnt("ar fresh", 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
